// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory-access / writeback pipeline stage
//
// Purpose:
//   Takes the EX/WB pipeline register of the execute stage, performs the
//   data-memory access of loads and stores over a req/ready handshake,
//   extends load data and drives the register-file write port. While an
//   access is in flight, stall_read holds the EX/WB register.
//
// Optional feature:
//   MISALIGN_TRAP_EN - when defined, misaligned LH/LHU/LW/SH/SW accesses are
//   not issued to memory; a one-cycle 'misaligned' pulse is raised instead.
//
// Parameters:
//   TIMEOUT_CYCLES - max cycles in REQ waiting for dmem_ready (0 = no limit)
//   TMO_W          - timeout counter width, TIMEOUT_CYCLES < 2**TMO_W
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   ex_result                     ALU result / store data / return address
//   ex_mem_addr                   data-memory byte address
//   ex_mem_write, ex_mem_to_reg   store / load in WB
//   ex_alu_to_reg                 instruction writes rd
//   ex_dest_reg_sel               rd
//   ex_read_address               byte offset addr[1:0]
//   ex_alu_operation              funct3 (load/store width and signedness)
//   stall_read                    1 = hold EX/WB register
//   dmem_req/we/addr/wdata/wstrb  registered memory request
//   dmem_ready, dmem_rdata        access complete, read word
//   dmem_err                      one-cycle pulse on request timeout
//   misaligned                    one-cycle pulse (MISALIGN_TRAP_EN only)
//   rf_we, rf_waddr, rf_wdata     register-file write port

module mem_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_mem_addr,
  input  logic        ex_mem_write,
  input  logic        ex_alu_to_reg,
  input  logic        ex_mem_to_reg,
  input  logic [4:0]  ex_dest_reg_sel,
  input  logic [1:0]  ex_read_address,
  input  logic [2:0]  ex_alu_operation,
  output logic        stall_read,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_err,
`ifdef MISALIGN_TRAP_EN
  output logic        misaligned,
`endif
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    LOAD_WB = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic               dmem_req_q, dmem_req_d;
  logic               dmem_we_q, dmem_we_d;
  logic [31:0]        dmem_addr_q, dmem_addr_d;
  logic [31:0]        dmem_wdata_q, dmem_wdata_d;
  logic [3:0]         dmem_wstrb_q, dmem_wstrb_d;
  logic               dmem_err_q, dmem_err_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  // Load buffer: read word plus the decode needed to extend it in LOAD_WB.
  logic [31:0]        ld_data_q, ld_data_d;
  logic [2:0]         ld_f3_q, ld_f3_d;
  logic [1:0]         ld_off_q, ld_off_d;
  logic [4:0]         ld_rd_q, ld_rd_d;
  logic               mis_q, mis_d;

  // Byte offset travels separately on ex_read_address; the word address
  // never needs the low bits.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, ex_mem_addr[1:0]};

  // Store wins when both mem flags are set.
  logic is_store, is_load, mem_op;
  assign is_store = ex_mem_write;
  assign is_load  = ex_mem_to_reg & ~ex_mem_write;
  assign mem_op   = ex_mem_write | ex_mem_to_reg;

  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    load_extend = {{24{b[7]}}, b};
      3'd1:    load_extend = {{16{h[15]}}, h};
      3'd2:    load_extend = w;
      3'd4:    load_extend = {24'b0, b};
      3'd5:    load_extend = {16'b0, h};
      default: load_extend = w;
    endcase
  endfunction

  // Lane-replicated store data and byte strobes for the current instruction.
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  always_comb begin
    st_wdata = ex_result;
    st_wstrb = 4'b0000;
    case (ex_alu_operation)
      3'd0: begin
        st_wdata = {4{ex_result[7:0]}};
        st_wstrb = 4'b0001 << ex_read_address;
      end
      3'd1: begin
        st_wdata = {2{ex_result[15:0]}};
        st_wstrb = ex_read_address[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        st_wdata = ex_result;
        st_wstrb = 4'b1111;
      end
      default: begin
        st_wdata = ex_result;
        st_wstrb = 4'b0000;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  function automatic logic misaligned_access(input logic       store,
                                             input logic [2:0] f3,
                                             input logic [1:0] off);
    logic half, word;
    half = (f3 == 3'd1) || (!store && (f3 == 3'd5));
    word = (f3 == 3'd2);
    misaligned_access = (half && off[0]) || (word && (off != 2'b00));
  endfunction

  logic mis_now;
  assign mis_now = misaligned_access(is_store, ex_alu_operation, ex_read_address);
`else
  logic mis_now;
  assign mis_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      dmem_wstrb_q <= 4'd0;
      dmem_err_q   <= 1'b0;
      cnt_q        <= '0;
      ld_data_q    <= 32'd0;
      ld_f3_q      <= 3'd0;
      ld_off_q     <= 2'd0;
      ld_rd_q      <= 5'd0;
      mis_q        <= 1'b0;
    end else begin
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wstrb_q <= dmem_wstrb_d;
      dmem_err_q   <= dmem_err_d;
      cnt_q        <= cnt_d;
      ld_data_q    <= ld_data_d;
      ld_f3_q      <= ld_f3_d;
      ld_off_q     <= ld_off_d;
      ld_rd_q      <= ld_rd_d;
      mis_q        <= mis_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wstrb_d = dmem_wstrb_q;
    dmem_err_d   = 1'b0;
    cnt_d        = cnt_q;
    ld_data_d    = ld_data_q;
    ld_f3_d      = ld_f3_q;
    ld_off_d     = ld_off_q;
    ld_rd_d      = ld_rd_q;
    mis_d        = 1'b0;
    stall_read   = 1'b0;
    rf_we        = 1'b0;
    rf_waddr     = ex_dest_reg_sel;
    rf_wdata     = ex_result;

    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall_read = 1'b1;
          if (mis_now) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d      = REQ;
            dmem_req_d   = 1'b1;
            dmem_we_d    = is_store;
            dmem_addr_d  = {ex_mem_addr[31:2], 2'b00};
            dmem_wdata_d = is_store ? st_wdata : 32'd0;
            dmem_wstrb_d = is_store ? st_wstrb : 4'b0000;
            cnt_d        = '0;
            ld_f3_d      = ex_alu_operation;
            ld_off_d     = ex_read_address;
            ld_rd_d      = ex_dest_reg_sel;
          end
        end else begin
          rf_we = ex_alu_to_reg & (ex_dest_reg_sel != 5'd0);
        end
      end

      REQ: begin
        stall_read = 1'b1;
        cnt_d      = cnt_q + TMO_W'(1);
        if (dmem_ready) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (dmem_we_q) begin
            state_d = DONE;
          end else begin
            ld_data_d = dmem_rdata;
            state_d   = LOAD_WB;
          end
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          dmem_err_d = 1'b1;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          state_d    = DONE;
        end
      end

      LOAD_WB: begin
        rf_we    = (ld_rd_q != 5'd0);
        rf_waddr = ld_rd_q;
        rf_wdata = load_extend(ld_data_q, ld_f3_q, ld_off_q);
        state_d  = IDLE;
      end

      DONE: begin
        // One idle slot so the instruction held by stall_read is consumed,
        // never re-issued.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Combinational outputs follow the register reset while it is asserted.
    if (!reset_n) begin
      stall_read = 1'b0;
      rf_we      = 1'b0;
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_wstrb = dmem_wstrb_q;
  assign dmem_err   = dmem_err_q;
`ifdef MISALIGN_TRAP_EN
  assign misaligned = mis_q;
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumes the EX/WB pipeline register outputs of the execute stage.
- Performs the data-memory access for loads and stores over a req/ready handshake.
- Aligns and sign- or zero-extends load data, then drives the register-file write port.
- Holds the EX/WB register through `stall_read` while a memory access is outstanding.

Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent in REQ waiting for `dmem_ready`. A value of 0 disables the timeout.
- `TMO_W`, default 8: width of the timeout counter. Must satisfy `TIMEOUT_CYCLES < 2**TMO_W`.

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `ex_result`  in  32  ALU result / store data / return address
- `ex_mem_addr`  in  32  data-memory byte address of the load/store
- `ex_mem_write`  in  1  store in WB
- `ex_alu_to_reg`  in  1  instruction writes rd
- `ex_mem_to_reg`  in  1  load in WB
- `ex_dest_reg_sel`  in  5  rd
- `ex_read_address`  in  2  byte offset `addr[1:0]`
- `ex_alu_operation`  in  3  funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2)
- `stall_read`  out  1  1 = hold EX/WB register
- `dmem_req`  out  1  access request
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  32  word-aligned address `{ex_mem_addr[31:2], 2'b00}`
- `dmem_wdata`  out  32  store data, lane-replicated
- `dmem_wstrb`  out  4  byte strobes
- `dmem_ready`  in  1  access complete; read data valid in the same cycle
- `dmem_rdata`  in  32  read word
- `dmem_err`  out  1  one-cycle pulse on timeout
- `rf_we`  out  1  register-file write enable
- `rf_waddr`  out  5  rd
- `rf_wdata`  out  32  write data

Behaviour:
- FSM states: IDLE, REQ, LOAD_WB, DONE. Reset state is IDLE.
- Reset (asynchronous): all registered outputs are cleared (`dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_wstrb`, `dmem_err`), along with the load buffer and the counter. `rf_we` = 0 and `stall_read` = 0.
- Reset mid-access: `dmem_req` drops immediately, the transaction is abandoned, and no rf write occurs.
- IDLE, no memory op:
  - `rf_we` = `ex_alu_to_reg` & (rd≠0); `rf_wdata` = `ex_result`; `stall_read` = 0.
  - All combinational, giving a zero-latency writeback.
- IDLE with `ex_mem_to_reg` or `ex_mem_write`:
  - `stall_read` = 1 and `rf_we` = 0.
  - Next edge: enter REQ with `dmem_req`=1, `dmem_we`=`ex_mem_write`, and address/data/strobes registered.
  - If both `ex_mem_to_reg` and `ex_mem_write` are set, the store takes priority.
- REQ:
  - `dmem_req` and its fields are held stable; `stall_read` = 1; the counter increments each cycle.
  - On `dmem_ready`=1: `dmem_req` drops next edge. A load latches `dmem_rdata` and goes to LOAD_WB; a store goes to DONE.
  - If the counter reaches `TIMEOUT_CYCLES` without ready: pulse `dmem_err`, drop `dmem_req`, go to DONE. No rf write.
- LOAD_WB:
  - `rf_we` = (rd≠0); `rf_wdata` = extended load data; `stall_read` = 0.
  - Goes to IDLE; the EX/WB register advances on the same edge.
- DONE: `stall_read` = 0, `rf_we` = 0, go to IDLE. This state guarantees a held instruction is never re-issued.
- Minimum latency: load 3 cycles in WB, store 3 cycles in WB (ready asserted in the first REQ cycle).
- Load extraction, with `ex_read_address` = off:
  - LB/LBU: byte lane `off`, sign-/zero-extended.
  - LH/LHU: half `off[1]`.
  - LW: full word.
  - Unknown funct3: zero-extended word.
- Stores:
  - SB: `wdata` = {4{byte}}, `wstrb` = 1<<off.
  - SH: `wdata` = {2{half}}, `wstrb` = `off[1]` ? 1100 : 0011.
  - SW: `wstrb` = 1111.
  - Other funct3: `wstrb` = 0000 (no bytes written; handshake still performed).
- `dmem_ready` outside REQ is ignored.
- rd=0 never produces `rf_we`=1.

Optional Feature:
- Macro: `MISALIGN_TRAP_EN`.
- Defined:
  - In IDLE, an LH/LHU/SH with `off[0]`=1, or an LW/SW with off≠0, is detected as misaligned.
  - No memory request is issued. `misaligned` (extra output, 1 bit, reset 0) pulses for one cycle and the FSM goes directly to DONE. No rf write.
- Undefined: low offset bits are ignored as described above; no `misaligned` port exists.

Test Plan:
- ALU writeback: `ex_alu_to_reg`=1, rd=5, `ex_result`=0x1234 → same cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234, `stall_read`=0; rd=0 → `rf_we`=0.
- LB: `ex_mem_addr`=0x103, `ex_read_address`=3, `dmem_rdata`=0x80FF_0000, ready in first REQ cycle → `dmem_addr`=0x100, `stall_read` high for 2 cycles, LOAD_WB `rf_wdata`=0xFFFF_FF80; repeat as LBU → 0x0000_0080.
- SH: offset 2, `ex_result`=0xDEAD_BEEF, ready after 3 wait cycles → `dmem_we`=1, `dmem_wdata`=0xBEEF_BEEF, `dmem_wstrb`=1100, `stall_read` high for 5 cycles, no rf write.
- Timeout: `TIMEOUT_CYCLES`=4, load, `dmem_ready` never asserted → `dmem_err` pulse after 4 REQ cycles, `rf_we` stays 0, next instruction advances.
- Reset mid-access: `reset_n`=0 during REQ → `dmem_req`=0 immediately, state IDLE; after release, no spurious request.
- `MISALIGN_TRAP_EN`: LW at offset 1 → `misaligned`=1 for one cycle, `dmem_req` stays 0, no rf write.
